alu_sequencer: RTL

Instruction controller for the BitBlaster 10-bit processor. Captures one 10-bit instruction per `Exec` request and steps it through T0–T3, driving the ALU (`Ain`, `Gin`, `Gout`, `FN`), the register-file enables, and the shared-bus source selects. It reports completion with `Done`. It sits between the instruction/switch inputs and the register file, ALU, and shared 10-bit bus.

---
 rtl/bitblaster_pkg.sv | 56 +++++
 rtl/alu_sequencer_if.sv | 41 ++++
 rtl/instr_decode.sv | 48 ++++
 rtl/alu_sequencer.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/bitblaster_pkg.sv
// Shared BitBlaster definitions: ALU function codes, instruction classes and sequencer step encoding.
// Used by the sequencer, the ALU and the disassembly/display logic.
package bitblaster_pkg;

   localparam int INSTR_W = 10;

   localparam logic [3:0] FN_LOAD = 4'b0000;
   localparam logic [3:0] FN_COPY = 4'b0001;
   localparam logic [3:0] FN_ADD  = 4'b0010;
   localparam logic [3:0] FN_SUB  = 4'b0011;
   localparam logic [3:0] FN_INV  = 4'b0100;
   localparam logic [3:0] FN_FLP  = 4'b0101;
   localparam logic [3:0] FN_AND  = 4'b0110;
   localparam logic [3:0] FN_OR   = 4'b0111;
   localparam logic [3:0] FN_XOR  = 4'b1000;
   localparam logic [3:0] FN_LSL  = 4'b1001;
   localparam logic [3:0] FN_LSR  = 4'b1010;
   localparam logic [3:0] FN_ASR  = 4'b1011;
   localparam logic [3:0] FN_ADDI = 4'b1100;
   localparam logic [3:0] FN_SUBI = 4'b1101;

   localparam logic [1:0] CLS_ALU     = 2'b00;
   localparam logic [1:0] CLS_ILLEGAL = 2'b01;
   localparam logic [1:0] CLS_ADDI    = 2'b10;
   localparam logic [1:0] CLS_SUBI    = 2'b11;

   typedef enum logic [1:0] {
      T0 = 2'b00,
      T1 = 2'b01,
      T2 = 2'b10,
      T3 = 2'b11
   } step_t;

   typedef enum logic [2:0] {
      OP_LD      = 3'd0,
      OP_CP      = 3'd1,
      OP_UNARY   = 3'd2,
      OP_BINARY  = 3'd3,
      OP_IMM     = 3'd4,
      OP_ILLEGAL = 3'd5
   } op_kind_t;

   // Sequencing shape of a class-00 function code; codes 1100-1111 have no meaning there.
   function automatic op_kind_t alu_kind(input logic [3:0] fn);
      case (fn)
         FN_LOAD:                 alu_kind = OP_LD;
         FN_COPY:                 alu_kind = OP_CP;
         FN_INV, FN_FLP:          alu_kind = OP_UNARY;
         FN_ADD, FN_SUB, FN_AND, FN_OR,
         FN_XOR, FN_LSL, FN_LSR, FN_ASR:
                                  alu_kind = OP_BINARY;
         default:                 alu_kind = OP_ILLEGAL;
      endcase
   endfunction

endpackage

// File: rtl/alu_sequencer_if.sv
// Control/bus interface between the BitBlaster sequencer and its instruction source and datapath.
// Carries the Illegal flag only when ALU_SEQ_ILLEGAL_TRAP_EN is defined.
interface alu_sequencer_if
   import bitblaster_pkg::*;
#(
   parameter int NREG = 4
);
   logic [INSTR_W-1:0] Instr;
   logic               Exec;
   logic [INSTR_W-1:0] IR;
   logic [3:0]         FN;
   logic               Ain;
   logic               Gin;
   logic               Gout;
   logic [NREG-1:0]    Rin;
   logic [NREG-1:0]    Rout;
   logic               ExtDataOut;
   logic               IMMout;
   logic [INSTR_W-1:0] ImmVal;
   logic               Done;
`ifdef ALU_SEQ_ILLEGAL_TRAP_EN
   logic               Illegal;
`endif

   modport slave (
      input  Instr, Exec,
      output IR, FN, Ain, Gin, Gout, Rin, Rout, ExtDataOut, IMMout, ImmVal, Done
`ifdef ALU_SEQ_ILLEGAL_TRAP_EN
      , output Illegal
`endif
   );

   modport master (
      output Instr, Exec,
      input  IR, FN, Ain, Gin, Gout, Rin, Rout, ExtDataOut, IMMout, ImmVal, Done
`ifdef ALU_SEQ_ILLEGAL_TRAP_EN
      , input Illegal
`endif
   );

endinterface

// File: rtl/instr_decode.sv
// Purely combinational field decode of the held instruction register.
// Produces operand indices, ALU function, sequencing kind and the zero-extended immediate.
module instr_decode
   import bitblaster_pkg::*;
#(
   parameter int IMM_W = 6
) (
   input  logic [INSTR_W-1:0] ir,
   output logic [1:0]         x,
   output logic [1:0]         y,
   output logic [3:0]         fn,
   output op_kind_t           kind,
   output logic [INSTR_W-1:0] imm_val
);

   assign x       = ir[7:6];
   assign y       = ir[5:4];
   assign imm_val = {{(INSTR_W-IMM_W){1'b0}}, ir[IMM_W-1:0]};

   // Class select: immediate classes carry a fixed ALU function, class 01 is reserved.
   always_comb begin
      fn   = FN_LOAD;
      kind = OP_ILLEGAL;
      case (ir[9:8])
         CLS_ALU: begin
            fn   = ir[3:0];
            kind = alu_kind(ir[3:0]);
         end
         CLS_ADDI: begin
            fn   = FN_ADDI;
            kind = OP_IMM;
         end
         CLS_SUBI: begin
            fn   = FN_SUBI;
            kind = OP_IMM;
         end
         CLS_ILLEGAL: begin
            fn   = FN_LOAD;
            kind = OP_ILLEGAL;
         end
         default: begin
            fn   = FN_LOAD;
            kind = OP_ILLEGAL;
         end
      endcase
   end

endmodule

// File: rtl/alu_sequencer.sv
// BitBlaster instruction sequencer: accepts one instruction per Exec and steps it through T0-T3.
// Optional macro ALU_SEQ_ILLEGAL_TRAP_EN adds a sticky Illegal flag that halts acceptance until reset.
module alu_sequencer
   import bitblaster_pkg::*;
#(
   parameter int IMM_W = 6,
   parameter int NREG  = 4
) (
   input logic           CLKb,
   input logic           Rst,
   alu_sequencer_if.slave bus
);

   step_t              state_r;
   step_t              state_nxt_s;
   logic [INSTR_W-1:0] ir_r;
   logic               accept_s;
   logic               halt_s;

   logic [1:0]         x_s;
   logic [1:0]         y_s;
   logic [3:0]         fn_s;
   op_kind_t           kind_s;
   logic [INSTR_W-1:0] imm_val_s;

   logic [3:0]         fn_out_s;
   logic               ain_s;
   logic               gin_s;
   logic               gout_s;
   logic [NREG-1:0]    rin_s;
   logic [NREG-1:0]    rout_s;
   logic               ext_s;
   logic               immout_s;
   logic               done_s;

   function automatic logic [NREG-1:0] reg_sel(input logic [1:0] idx);
      reg_sel = '0;
      for (int i = 0; i < NREG; i++) begin
         if ({30'd0, idx} == 32'(i)) begin
            reg_sel[i] = 1'b1;
         end else begin
            reg_sel[i] = 1'b0;
         end
      end
   endfunction

   instr_decode #(
      .IMM_W (IMM_W)
   ) u_decode (
      .ir      (ir_r),
      .x       (x_s),
      .y       (y_s),
      .fn      (fn_s),
      .kind    (kind_s),
      .imm_val (imm_val_s)
   );

`ifdef ALU_SEQ_ILLEGAL_TRAP_EN
   logic illegal_r;
   logic illegal_set_s;

   assign illegal_set_s = (state_r == T1) && (kind_s == OP_ILLEGAL);
   assign halt_s        = illegal_r;
   // The flag is visible already during the offending T1 step.
   assign bus.Illegal   = illegal_r | illegal_set_s;

   // Sticky trap flag, cleared only by reset.
   always_ff @(negedge CLKb or posedge Rst) begin
      if (Rst) begin
         illegal_r <= 1'b0;
      end else if (illegal_set_s) begin
         illegal_r <= 1'b1;
      end
   end
`else
   assign halt_s = 1'b0;
`endif

   // State and instruction register; everything advances on the falling clock edge.
   always_ff @(negedge CLKb or posedge Rst) begin
      if (Rst) begin
         state_r <= T0;
         ir_r    <= '0;
      end else begin
         state_r <= state_nxt_s;
         if (accept_s) begin
            ir_r <= bus.Instr;
         end
      end
   end

   // Next step and datapath control decoded from the current step and held instruction.
   always_comb begin
      state_nxt_s = state_r;
      accept_s    = 1'b0;
      fn_out_s    = 4'b0000;
      ain_s       = 1'b0;
      gin_s       = 1'b0;
      gout_s      = 1'b0;
      rin_s       = '0;
      rout_s      = '0;
      ext_s       = 1'b0;
      immout_s    = 1'b0;
      done_s      = 1'b0;
      case (state_r)
         T0: begin
            if (bus.Exec && !halt_s) begin
               accept_s    = 1'b1;
               state_nxt_s = T1;
            end else begin
               state_nxt_s = T0;
            end
         end
         T1: begin
            state_nxt_s = T2;
            case (kind_s)
               OP_LD: begin
                  ext_s       = 1'b1;
                  rin_s       = reg_sel(x_s);
                  done_s      = 1'b1;
                  state_nxt_s = T0;
               end
               OP_CP: begin
                  rout_s      = reg_sel(y_s);
                  rin_s       = reg_sel(x_s);
                  done_s      = 1'b1;
                  state_nxt_s = T0;
               end
               OP_UNARY: begin
                  rout_s = reg_sel(y_s);
                  ain_s  = 1'b1;
               end
               OP_BINARY, OP_IMM: begin
                  rout_s = reg_sel(x_s);
                  ain_s  = 1'b1;
               end
               default: begin
                  done_s      = 1'b1;
                  state_nxt_s = T0;
               end
            endcase
         end
         T2: begin
            state_nxt_s = T3;
            fn_out_s    = fn_s;
            gin_s       = 1'b1;
            case (kind_s)
               OP_BINARY: rout_s   = reg_sel(y_s);
               OP_IMM:    immout_s = 1'b1;
               default:   immout_s = 1'b0;
            endcase
         end
         T3: begin
            state_nxt_s = T0;
            gout_s      = 1'b1;
            rin_s       = reg_sel(x_s);
            done_s      = 1'b1;
         end
         default: begin
            state_nxt_s = T0;
         end
      endcase
   end

   assign bus.IR         = ir_r;
   assign bus.FN         = fn_out_s;
   assign bus.Ain        = ain_s;
   assign bus.Gin        = gin_s;
   assign bus.Gout       = gout_s;
   assign bus.Rin        = rin_s;
   assign bus.Rout       = rout_s;
   assign bus.ExtDataOut = ext_s;
   assign bus.IMMout     = immout_s;
   assign bus.ImmVal     = imm_val_s;
   assign bus.Done       = done_s;

endmodule
